garegga_gfx_arb: RTL



---
 rtl/garegga_gfx_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/garegga_gfx_arb.sv
// garegga_gfx_arb: four-way arbiter in front of the shared GFX ROM port.
// Requester 0 (OBJ) may take absolute priority; otherwise the four requesters
// rotate round-robin. Each requester has a 32-bit data lane that holds
// its last completed word. Stuck ROM transactions are aborted after TIMEOUT
// WAIT cycles, and a sticky error flag is raised.
module garegga_gfx_arb #(
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          PRIO_OBJ = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   REQ_CS,
    input  logic [87:0]  REQ_ADDR,
    output logic [3:0]   REQ_OK,
    output logic [127:0] REQ_DOUT,
    output logic         ROM_CS,
    output logic [21:0]  ROM_ADDR,
    input  logic         ROM_OK,
    input  logic [31:0]  ROM_DOUT,
    output logic         BUSY,
    output logic         TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // WAIT-cycle count value on which an unanswered transaction is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nx;

    logic [1:0]  r_g;
    logic [1:0]  r_last;
    logic [21:0] r_addr;
    logic [7:0]  r_cnt;
    logic        r_cxl;
    logic [3:0]  r_ok;
    logic [31:0] r_dout [4];
    logic        r_err;

    logic [1:0]  w_base;
    logic [7:0]  w_dbl;
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_pick;
    logic [21:0] w_lane_addr;
    logic        w_fin;
    logic        w_tmo;
    logic        w_cxl_now;

    // Grant selection: rotate requests so the search starts at LAST+1,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        w_base = r_last + 2'd1;
        w_dbl  = {REQ_CS, REQ_CS} >> w_base;
        w_rot  = w_dbl[3:0];
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else begin
            w_off = 2'd3;
        end
        w_pick = w_base + w_off;
        if (PRIO_OBJ && REQ_CS[0]) begin
            w_pick = 2'd0;
        end
    end

    // Address lane of the requester about to be granted.
    always_comb begin
        case (w_pick)
            2'd0:    w_lane_addr = REQ_ADDR[21:0];
            2'd1:    w_lane_addr = REQ_ADDR[43:22];
            2'd2:    w_lane_addr = REQ_ADDR[65:44];
            default: w_lane_addr = REQ_ADDR[87:66];
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, completion/timeout decode and ROM-side outputs.
    always_comb begin
        w_state_nx = r_state;
        w_fin      = 1'b0;
        w_tmo      = 1'b0;
        w_cxl_now  = r_cxl | ~REQ_CS[r_g];
        ROM_CS     = 1'b0;
        BUSY       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (|REQ_CS) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ROM_CS = 1'b1;
                if (ROM_OK) begin
                    w_fin      = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (r_cnt == TMO_LAST) begin
                    w_fin      = 1'b1;
                    w_tmo      = 1'b1;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Transaction datapath: grant latch, WAIT counter, cancel tracking,
    // data lanes, OK pulse (raised on entry to DONE) and sticky error.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_g    <= '0;
            r_last <= 2'd3;
            r_addr <= '0;
            r_cnt  <= '0;
            r_cxl  <= 1'b0;
            r_ok   <= '0;
            r_err  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            r_ok <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|REQ_CS) begin
                        r_g    <= w_pick;
                        r_addr <= w_lane_addr;
                        r_cnt  <= '0;
                        r_cxl  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_cxl <= w_cxl_now;
                    r_cnt <= r_cnt + 8'd1;
                    if (w_fin) begin
                        r_last <= r_g;
                        if (!w_cxl_now) begin
                            r_ok[r_g]   <= 1'b1;
                            r_dout[r_g] <= w_tmo ? '0 : ROM_DOUT;
                        end
                        if (w_tmo) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ROM_ADDR    = r_addr;
    assign REQ_OK      = r_ok;
    assign REQ_DOUT    = {r_dout[3], r_dout[2], r_dout[1], r_dout[0]};
    assign TIMEOUT_ERR = r_err;

endmodule
